// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Multi-cycle stage controller for the non-pipelined core. Each instruction
// walks through IF, IF_WAIT, ID, EX, MEM, MEM_WAIT and WB. The controller
// drives the per-stage write enables and the stage-register clear.
// Features: minimum memory wait cycles, ready-gated waits, a global stall,
// halt/resume, and a retired-instruction counter.
//
// Parameters:
//   IF_WAIT   minimum cycles spent in IF_WAIT (>= 1)
//   MEM_WAIT  minimum cycles spent in MEM_WAIT (>= 1)
//   WCNT_W    wait counter width (2**WCNT_W > max(IF_WAIT, MEM_WAIT))
//   RET_W     retired-instruction counter width
//
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   imem_ready       instruction memory data valid
//   dmem_ready       data memory access complete
//   stall            freeze sequencer, all write enables forced low
//   halt_req         sampled in WB, enter HALT instead of IF
//   resume           leave HALT
//   pc_wren .. reg_wren  per-stage write enables / strobes
//   stage_reset_n    active-low clear of stage registers
//   stage            current state encoding
//   halted           high while in HALT
//   retire           one-cycle pulse per completed instruction
//   retired_count    completed instruction count (wraps)
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter int IF_WAIT  = 1,
  parameter int MEM_WAIT = 1,
  parameter int WCNT_W   = 4,
  parameter int RET_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_wren,
  output logic             if_id_wren,
  output logic             id_ex_wren,
  output logic             ex_mem_wren,
  output logic             mem_wb_wren,
  output logic             ram_wren,
  output logic             reg_wren,
  output logic             stage_reset_n,
  output logic [3:0]       stage,
  output logic             halted,
  output logic             retire,
  output logic [RET_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_IF       = 4'd1,
    S_IF_WAIT  = 4'd2,
    S_ID       = 4'd3,
    S_EX       = 4'd4,
    S_MEM      = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_WB       = 4'd7,
    S_HALT     = 4'd8
  } state_t;

  // Last counter value that still counts as a wait cycle.
  // Reaching it allows the exit once the memory reports ready.
  localparam logic [WCNT_W-1:0] IF_LAST  = WCNT_W'(IF_WAIT - 1);
  localparam logic [WCNT_W-1:0] MEM_LAST = WCNT_W'(MEM_WAIT - 1);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_sat;
  logic              hold;
  logic              if_exit;
  logic              mem_exit;

  // Stall is ignored in INIT so that reset release always reaches IF.
  assign hold     = stall && (state != S_INIT);
  assign if_exit  = (state == S_IF_WAIT)  && (wcnt >= IF_LAST)  && imem_ready;
  assign mem_exit = (state == S_MEM_WAIT) && (wcnt >= MEM_LAST) && dmem_ready;

  // Saturating increment.
  // A long ready wait parks at all-ones instead of wrapping below the minimum.
  assign wcnt_sat = (&wcnt) ? wcnt : wcnt + WCNT_W'(1);

  assign stage = state;

  // State, wait counter and retired counter.
  // wcnt defaults to zero so that every state change clears it.
  // Only a wait state that stays put advances the counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_INIT;
      wcnt          <= '0;
      retired_count <= '0;
    end else if (!hold) begin
      wcnt <= '0;
      if (state == S_WB) begin
        retired_count <= retired_count + RET_W'(1);
      end
      case (state)
        S_INIT:    state <= S_IF;
        S_IF:      state <= S_IF_WAIT;
        S_IF_WAIT: begin
          if (if_exit) begin
            state <= S_ID;
          end else begin
            wcnt <= wcnt_sat;
          end
        end
        S_ID:      state <= S_EX;
        S_EX:      state <= S_MEM;
        S_MEM:     state <= S_MEM_WAIT;
        S_MEM_WAIT: begin
          if (mem_exit) begin
            state <= S_WB;
          end else begin
            wcnt <= wcnt_sat;
          end
        end
        S_WB:      state <= halt_req ? S_HALT : S_IF;
        S_HALT: begin
          if (resume) begin
            state <= S_IF;
          end
        end
        default:   state <= S_INIT;
      endcase
    end
  end

  // Moore decode of the current state.
  // The wait states raise their load enable only in the exit cycle.
  // A stall suppresses every enable and the retire pulse.
  // A stall leaves stage_reset_n and halted untouched.
  always_comb begin
    pc_wren       = 1'b0;
    if_id_wren    = 1'b0;
    id_ex_wren    = 1'b0;
    ex_mem_wren   = 1'b0;
    mem_wb_wren   = 1'b0;
    ram_wren      = 1'b0;
    reg_wren      = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;
    stage_reset_n = 1'b0;
    case (state)
      S_IF:       stage_reset_n = 1'b1;
      S_IF_WAIT: begin
        stage_reset_n = 1'b1;
        if_id_wren    = if_exit;
      end
      S_ID: begin
        stage_reset_n = 1'b1;
        id_ex_wren    = 1'b1;
      end
      S_EX: begin
        stage_reset_n = 1'b1;
        ex_mem_wren   = 1'b1;
      end
      S_MEM: begin
        stage_reset_n = 1'b1;
        pc_wren       = 1'b1;
        ram_wren      = 1'b1;
      end
      S_MEM_WAIT: begin
        stage_reset_n = 1'b1;
        mem_wb_wren   = mem_exit;
      end
      S_WB: begin
        reg_wren = 1'b1;
        retire   = 1'b1;
      end
      S_HALT:     halted = 1'b1;
      default:    ;
    endcase
    if (hold) begin
      pc_wren     = 1'b0;
      if_id_wren  = 1'b0;
      id_ex_wren  = 1'b0;
      ex_mem_wren = 1'b0;
      mem_wb_wren = 1'b0;
      ram_wren    = 1'b0;
      reg_wren    = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Testbench for stage_sequencer.
// dut uses default parameters. It runs a table of per-cycle vectors, followed
// by hand-written corner sequences: imem wait, stall in EX, halt/resume,
// stall in WB, and reset during MEM_WAIT.
// dut2 uses IF_WAIT=3, MEM_WAIT=2 and a 2-bit wait counter. It checks the
// 10-cycle period and that the wait counter saturates.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

  // Write-enable vector order: {pc, if_id, id_ex, ex_mem, mem_wb, ram, reg}.
  localparam logic [6:0] W_NONE  = 7'b0000000;
  localparam logic [6:0] W_IFID  = 7'b0100000;
  localparam logic [6:0] W_IDEX  = 7'b0010000;
  localparam logic [6:0] W_EXMEM = 7'b0001000;
  localparam logic [6:0] W_MEM   = 7'b1000010;
  localparam logic [6:0] W_MEMWB = 7'b0000100;
  localparam logic [6:0] W_WB    = 7'b0000001;

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        imr;
    logic        dmr;
    logic        hreq;
    logic        res;
    logic [3:0]  st;
    logic [6:0]  wen;
    logic        srn;
    logic        hlt;
    logic        rt;
    logic [31:0] ret;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n, imem_ready, dmem_ready, stall, halt_req, resume;
  logic        pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
  logic        ram_wren, reg_wren, stage_reset_n, halted, retire;
  logic [3:0]  stage;
  logic [31:0] retired_count;

  logic        reset2_n, imr2;
  logic        dmr2   = 1'b1;
  logic        stall2 = 1'b0;
  logic        hreq2  = 1'b0;
  logic        res2   = 1'b0;
  logic        pc2, ifid2, idex2, exmem2, memwb2, ram2, reg2, srn2, halted2, retire2;
  logic [3:0]  stage2;
  logic [31:0] retired2;

  int checks = 0;
  int passes = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .stall(stall), .halt_req(halt_req), .resume(resume),
    .pc_wren(pc_wren), .if_id_wren(if_id_wren), .id_ex_wren(id_ex_wren),
    .ex_mem_wren(ex_mem_wren), .mem_wb_wren(mem_wb_wren), .ram_wren(ram_wren),
    .reg_wren(reg_wren), .stage_reset_n(stage_reset_n), .stage(stage),
    .halted(halted), .retire(retire), .retired_count(retired_count)
  );

  stage_sequencer #(.IF_WAIT(3), .MEM_WAIT(2), .WCNT_W(2), .RET_W(32)) dut2 (
    .clk(clk), .reset_n(reset2_n), .imem_ready(imr2), .dmem_ready(dmr2),
    .stall(stall2), .halt_req(hreq2), .resume(res2),
    .pc_wren(pc2), .if_id_wren(ifid2), .id_ex_wren(idex2),
    .ex_mem_wren(exmem2), .mem_wb_wren(memwb2), .ram_wren(ram2),
    .reg_wren(reg2), .stage_reset_n(srn2), .stage(stage2),
    .halted(halted2), .retire(retire2), .retired_count(retired2)
  );

  function automatic vec_t mk(logic rst_n, logic stl, logic imr, logic dmr,
                              logic hreq, logic res, logic [3:0] st, logic [6:0] wen,
                              logic srn, logic hlt, logic rt, logic [31:0] ret);
    vec_t v;
    v.rst_n = rst_n; v.stl = stl; v.imr = imr; v.dmr = dmr; v.hreq = hreq; v.res = res;
    v.st = st; v.wen = wen; v.srn = srn; v.hlt = hlt; v.rt = rt; v.ret = ret;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n    = v.rst_n;
    stall      = v.stl;
    imem_ready = v.imr;
    dmem_ready = v.dmr;
    halt_req   = v.hreq;
    resume     = v.res;
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    cmp({name, ".stage"}, 32'(stage), 32'(v.st));
    cmp({name, ".wren"}, 32'({pc_wren, if_id_wren, id_ex_wren, ex_mem_wren,
                              mem_wb_wren, ram_wren, reg_wren}), 32'(v.wen));
    cmp({name, ".stage_reset_n"}, 32'(stage_reset_n), 32'(v.srn));
    cmp({name, ".halted"}, 32'(halted), 32'(v.hlt));
    cmp({name, ".retire"}, 32'(retire), 32'(v.rt));
    cmp({name, ".retired_count"}, retired_count, v.ret);
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v);
    tick();
  endtask

  initial begin : main
    int exp_st[10];
    exp_st = '{1, 2, 2, 2, 3, 4, 5, 6, 6, 7};

    // Table: reset, then three back-to-back 7-cycle instructions.
    tbl.push_back(mk(0,0,1,1,0,0, 4'd0, W_NONE, 0,0,0, 0));
    tbl.push_back(mk(1,0,1,1,0,0, 4'd0, W_NONE, 0,0,0, 0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(1,0,1,1,0,0, 4'd1, W_NONE,  1,0,0, 32'(k)));
      tbl.push_back(mk(1,0,1,1,0,0, 4'd2, W_IFID,  1,0,0, 32'(k)));
      tbl.push_back(mk(1,0,1,1,0,0, 4'd3, W_IDEX,  1,0,0, 32'(k)));
      tbl.push_back(mk(1,0,1,1,0,0, 4'd4, W_EXMEM, 1,0,0, 32'(k)));
      tbl.push_back(mk(1,0,1,1,0,0, 4'd5, W_MEM,   1,0,0, 32'(k)));
      tbl.push_back(mk(1,0,1,1,0,0, 4'd6, W_MEMWB, 1,0,0, 32'(k)));
      tbl.push_back(mk(1,0,1,1,0,0, 4'd7, W_WB,    0,0,1, 32'(k)));
    end
    tbl.push_back(mk(1,0,1,1,0,0, 4'd1, W_NONE, 1,0,0, 3));

    reset2_n = 1'b0;
    imr2     = 1'b1;
    reset_n = 1'b0; stall = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    halt_req = 1'b0; resume = 1'b0;
    tick();

    foreach (tbl[i]) runVec($sformatf("tbl%0d", i), tbl[i]);

    // imem_ready low for 5 cycles in IF_WAIT, then the pulse and ID.
    for (int i = 0; i < 5; i++) runVec("imem_wait", mk(1,0,0,1,0,0, 4'd2, W_NONE, 1,0,0, 3));
    runVec("imem_rise", mk(1,0,1,1,0,0, 4'd2, W_IFID, 1,0,0, 3));
    runVec("id_after_wait", mk(1,0,1,1,0,0, 4'd3, W_IDEX, 1,0,0, 3));
    // Stall for 4 cycles in EX.
    for (int i = 0; i < 4; i++) runVec("ex_stall", mk(1,1,1,1,0,0, 4'd4, W_NONE, 1,0,0, 3));
    runVec("ex_unstall", mk(1,0,1,1,0,0, 4'd4, W_EXMEM, 1,0,0, 3));
    runVec("mem", mk(1,0,1,1,0,0, 4'd5, W_MEM, 1,0,0, 3));
    runVec("mem_wait", mk(1,0,1,1,0,0, 4'd6, W_MEMWB, 1,0,0, 3));
    // halt_req together with resume in WB: HALT wins.
    runVec("wb_halt", mk(1,0,1,1,1,1, 4'd7, W_WB, 0,0,1, 3));
    for (int i = 0; i < 6; i++) runVec("halt", mk(1,0,1,1,0,0, 4'd8, W_NONE, 0,1,0, 4));
    runVec("halt_resume", mk(1,0,1,1,0,1, 4'd8, W_NONE, 0,1,0, 4));
    runVec("if_after_halt", mk(1,0,1,1,0,0, 4'd1, W_NONE, 1,0,0, 4));
    // A stall in WB hides halt_req and delays retire.
    runVec("i5_ifw", mk(1,0,1,1,0,0, 4'd2, W_IFID, 1,0,0, 4));
    runVec("i5_id", mk(1,0,1,1,0,0, 4'd3, W_IDEX, 1,0,0, 4));
    runVec("i5_ex", mk(1,0,1,1,0,0, 4'd4, W_EXMEM, 1,0,0, 4));
    runVec("i5_mem", mk(1,0,1,1,0,0, 4'd5, W_MEM, 1,0,0, 4));
    runVec("i5_mw", mk(1,0,1,1,0,0, 4'd6, W_MEMWB, 1,0,0, 4));
    runVec("wb_stall", mk(1,1,1,1,1,0, 4'd7, W_NONE, 0,0,0, 4));
    runVec("wb_unstall", mk(1,0,1,1,0,0, 4'd7, W_WB, 0,0,1, 4));
    runVec("if_after_wb", mk(1,0,1,1,0,0, 4'd1, W_NONE, 1,0,0, 5));
    // Reset during MEM_WAIT with dmem_ready low.
    runVec("i6_ifw", mk(1,0,1,0,0,0, 4'd2, W_IFID, 1,0,0, 5));
    runVec("i6_id", mk(1,0,1,0,0,0, 4'd3, W_IDEX, 1,0,0, 5));
    runVec("i6_ex", mk(1,0,1,0,0,0, 4'd4, W_EXMEM, 1,0,0, 5));
    runVec("i6_mem", mk(1,0,1,0,0,0, 4'd5, W_MEM, 1,0,0, 5));
    for (int i = 0; i < 3; i++) runVec("dmem_wait", mk(1,0,1,0,0,0, 4'd6, W_NONE, 1,0,0, 5));
    runVec("mw_reset", mk(0,0,1,0,0,0, 4'd6, W_NONE, 1,0,0, 5));
    runVec("init_stall", mk(1,1,1,1,0,0, 4'd0, W_NONE, 0,0,0, 0));
    runVec("if_after_rst", mk(1,0,1,1,0,0, 4'd1, W_NONE, 1,0,0, 0));
    runVec("ifw_after_rst", mk(1,0,1,1,0,0, 4'd2, W_IFID, 1,0,0, 0));
    runVec("id_after_rst", mk(1,0,1,1,0,0, 4'd3, W_IDEX, 1,0,0, 0));

    // dut2: IF_WAIT=3, MEM_WAIT=2 gives a 10-cycle period.
    reset2_n = 1'b1;
    #1;
    cmp("p2.init", 32'(stage2), 32'd0);
    tick();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        cmp($sformatf("p2.stage%0d_%0d", p, i), 32'(stage2), 32'(exp_st[i]));
        cmp($sformatf("p2.ifid%0d_%0d", p, i), 32'(ifid2), (i == 3) ? 32'd1 : 32'd0);
        cmp($sformatf("p2.memwb%0d_%0d", p, i), 32'(memwb2), (i == 8) ? 32'd1 : 32'd0);
        tick();
      end
    end
    cmp("p2.if", 32'(stage2), 32'd1);
    cmp("p2.retired", retired2, 32'd2);
    // A long imem wait must saturate the 2-bit counter rather than wrap it.
    imr2 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      cmp($sformatf("p2.sat_stage%0d", i), 32'(stage2), 32'd2);
      cmp($sformatf("p2.sat_ifid%0d", i), 32'(ifid2), 32'd0);
      tick();
    end
    imr2 = 1'b1;
    #1;
    cmp("p2.sat_exit", 32'(ifid2), 32'd1);
    tick();
    cmp("p2.sat_id", 32'(stage2), 32'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
